// File: rtl/coffee_brewer.sv
// Brewing-station responder: answers the controller's make handshake and
// sequences grinder, pump and milk valve around a debounced cup sensor.
module coffee_brewer #(
   parameter int unsigned GRIND_CYC = 8,
   parameter int unsigned BREW_CYC  = 20,
   parameter int unsigned MILK_CYC  = 12,
   parameter int unsigned DEB_CYC   = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Making,
   input  logic        Coffee,
   input  logic [1:0]  Kind,
   input  logic        CupSensor,
   output logic        Done,
   output logic        TakeOut,
   output logic        Grinder,
   output logic        Pump,
   output logic        MilkValve,
   output logic        CupAlarm,
   output logic        KindErr,
   output logic [15:0] ServedCnt
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_CUP,
      S_GRIND,
      S_BREW,
      S_MILK,
      S_PAUSE,
      S_DONE,
      S_SERVE,
      S_TAKE
   } state_t;

   localparam logic [1:0] KIND_AMERICANO = 2'b01;
   localparam logic [1:0] KIND_LATTE     = 2'b10;
   localparam logic [7:0] GRIND_LEN      = 8'(GRIND_CYC);
   localparam logic [7:0] BREW_LEN       = 8'(BREW_CYC);
   localparam logic [7:0] MILK_LEN       = 8'(MILK_CYC);
   localparam logic [7:0] DEB_LAST       = 8'(DEB_CYC - 1);

   logic        r_sync1;
   logic        r_sync2;
   logic        r_cup_ok;
   logic [7:0]  r_deb_cnt;

   state_t      r_state;
   state_t      r_held;
   logic [7:0]  r_timer;
   logic [1:0]  r_kind;
   logic        r_serve_idle;
   logic [15:0] r_served_cnt;

   state_t      w_state_nxt;
   state_t      w_held_nxt;
   logic [7:0]  w_timer_nxt;
   logic [1:0]  w_kind_nxt;
   logic        w_serve_idle_nxt;
   logic [15:0] w_served_nxt;

   function automatic logic kind_valid(input logic [1:0] k);
      return (k == KIND_AMERICANO) || (k == KIND_LATTE);
   endfunction

   // Cup sensor: 2-FF synchronizer, then a stability counter that restarts
   // whenever the synchronized value agrees with the debounced one again.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_cup_ok  <= 1'b0;
         r_deb_cnt <= '0;
      end else begin
         r_sync1 <= CupSensor;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_cup_ok) begin
            if (r_deb_cnt == DEB_LAST) begin
               r_cup_ok  <= r_sync2;
               r_deb_cnt <= '0;
            end else begin
               r_deb_cnt <= r_deb_cnt + 8'd1;
            end
         end else begin
            r_deb_cnt <= '0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_held       <= S_GRIND;
         r_timer      <= '0;
         r_kind       <= '0;
         r_serve_idle <= 1'b0;
         r_served_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_held       <= w_held_nxt;
         r_timer      <= w_timer_nxt;
         r_kind       <= w_kind_nxt;
         r_serve_idle <= w_serve_idle_nxt;
         r_served_cnt <= w_served_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_held_nxt       = r_held;
      w_timer_nxt      = r_timer;
      w_kind_nxt       = r_kind;
      w_serve_idle_nxt = 1'b0;
      w_served_nxt     = r_served_cnt;
      case (r_state)
         S_IDLE: begin
            if (Making) begin
               w_kind_nxt = Kind;
               if (!kind_valid(Kind)) begin
                  w_state_nxt = S_DONE;
               end else if (r_cup_ok) begin
                  w_state_nxt = S_GRIND;
                  w_timer_nxt = GRIND_LEN;
               end else begin
                  w_state_nxt = S_WAIT_CUP;
               end
            end
         end
         S_WAIT_CUP: begin
            if (!Making) begin
               w_state_nxt = S_IDLE;
            end else if (r_cup_ok) begin
               w_state_nxt = S_GRIND;
               w_timer_nxt = GRIND_LEN;
            end
         end
         S_GRIND, S_BREW, S_MILK: begin
            // Abort beats pause beats phase end; a pause on the last cycle
            // keeps the timer at 1 so that cycle is repeated on resume.
            if (!Making) begin
               w_state_nxt = S_IDLE;
               w_timer_nxt = '0;
            end else if (!r_cup_ok) begin
               w_state_nxt = S_PAUSE;
               w_held_nxt  = r_state;
               if (r_timer != 8'd1) begin
                  w_timer_nxt = r_timer - 8'd1;
               end
            end else if (r_timer == 8'd1) begin
               if (r_state == S_GRIND) begin
                  w_state_nxt = S_BREW;
                  w_timer_nxt = BREW_LEN;
               end else if ((r_state == S_BREW) && (r_kind == KIND_LATTE)) begin
                  w_state_nxt = S_MILK;
                  w_timer_nxt = MILK_LEN;
               end else begin
                  w_state_nxt = S_DONE;
                  w_timer_nxt = '0;
               end
            end else begin
               w_timer_nxt = r_timer - 8'd1;
            end
         end
         S_PAUSE: begin
            if (!Making) begin
               w_state_nxt = S_IDLE;
               w_timer_nxt = '0;
            end else if (r_cup_ok) begin
               w_state_nxt = r_held;
            end
         end
         S_DONE: begin
            w_state_nxt = S_SERVE;
         end
         S_SERVE: begin
            if (Coffee && !r_cup_ok) begin
               w_state_nxt  = S_TAKE;
               w_served_nxt = (r_served_cnt == 16'hFFFF) ? r_served_cnt
                                                          : r_served_cnt + 16'd1;
            end else if (!Making && !Coffee) begin
               if (r_serve_idle) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_serve_idle_nxt = 1'b1;
               end
            end
         end
         S_TAKE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      Grinder   = (r_state == S_GRIND);
      Pump      = (r_state == S_BREW);
      MilkValve = (r_state == S_MILK);
      CupAlarm  = (r_state == S_WAIT_CUP) || (r_state == S_PAUSE);
      Done      = (r_state == S_DONE);
      KindErr   = (r_state == S_DONE) && !kind_valid(r_kind);
      TakeOut   = (r_state == S_TAKE);
   end

   assign ServedCnt = r_served_cnt;

endmodule

// File: doc/coffee_brewer.md
Name: coffee_brewer

Overview:
- Brewing-station responder on the system side of the vending controller's make handshake.
- Consumes the controller's Making/Coffee levels and the stored drink kind, and sequences the grinder, pump and milk valve.
- Returns Done when a cup is filled and TakeOut when the customer removes it.
- Includes a debounced cup sensor with pause/resume and a served-cup counter.

Parameters:
GRIND_CYC, 8, grinder-on duration in clocks (1..255)
BREW_CYC, 20, pump-on duration in clocks (1..255)
MILK_CYC, 12, milk-valve-on duration in clocks, latte only (1..255)
DEB_CYC, 4, cycles cup sensor must be stable before its debounced value changes (1..255)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
Making  in  1  level from controller: high while it waits for Done
Coffee  in  1  level from controller: high while it waits for TakeOut
Kind  in  2  stored drink kind: 01 Americano, 10 Latte
CupSensor  in  1  raw, asynchronous cup-present sensor
Done  out  1  one-cycle pulse: cup filled
TakeOut  out  1  one-cycle pulse: filled cup removed
Grinder  out  1  grinder motor enable
Pump  out  1  hot-water pump enable
MilkValve  out  1  milk valve enable
CupAlarm  out  1  high while brewing is blocked by a missing cup
KindErr  out  1  one-cycle pulse: invalid Kind at start
ServedCnt  out  16  count of completed TakeOut handshakes

Behaviour:
- Reset: all outputs 0, ServedCnt=0, state IDLE, phase timer 0, debounced cup value (cup_ok)=0. Reset mid-brew drops every actuator in the same cycle, because the reset is asynchronous.
- Cup sensor path:
  - CupSensor passes a 2-FF synchronizer.
  - cup_ok takes the synchronized value only after that value has differed from cup_ok for DEB_CYC consecutive cycles.
  - Any glitch shorter than DEB_CYC restarts the count.
- The FSM is Moore. Outputs decode from the registered state, except ServedCnt, which is a register.
- States and transitions:
  - IDLE: if Making=1, latch Kind into kind_r. If kind_r is not 01/10, go to DONE and pulse KindErr on that same edge, with no actuation. Otherwise go to GRIND if cup_ok=1, else WAIT_CUP.
  - WAIT_CUP: CupAlarm=1. Go to GRIND when cup_ok=1. Return to IDLE if Making=0.
  - GRIND: Grinder=1 for GRIND_CYC cycles, then BREW.
  - BREW: Pump=1 for BREW_CYC cycles. Then go to MILK if kind_r=10, else DONE.
  - MILK: MilkValve=1 for MILK_CYC cycles, then DONE.
  - PAUSE:
    - Entered from GRIND, BREW or MILK when cup_ok falls.
    - Actuators off, CupAlarm=1, the remaining count and the interrupted phase are held.
    - Returns to the held phase when cup_ok=1, continuing the count without restarting it.
  - Abort: Making=0 in GRIND, BREW, MILK or PAUSE goes to IDLE, with actuators off the next cycle and no Done.
  - DONE: Done=1 for one cycle, then SERVE.
  - SERVE: wait for Coffee=1 and cup_ok=0, then TAKE. Go to IDLE if Making=0 and Coffee=0 persist for 2 cycles (controller reinitialised).
  - TAKE: TakeOut=1 for one cycle; ServedCnt increments, saturating at 16'hFFFF. Then IDLE.
- Timer rules:
  - The phase timer is 8 bits. It loads the phase length on phase entry and decrements each active cycle.
  - The phase ends on the cycle it reads 1, so each phase lasts exactly its parameter length.
- Latency: with cup_ok=1 and Making sampled high at edge k, Done is high in cycle k+GRIND_CYC+BREW_CYC. For a latte add MILK_CYC.
- Simultaneous events:
  - cup_ok fall on the final cycle of a phase: PAUSE takes priority and the phase's last cycle is redone after resume.
  - Making=0 and cup_ok fall together: the abort wins.
- The next brew starts only from IDLE. The controller re-raises Making two cycles after TakeOut; that request must be accepted.

Test Plan:
- Americano, cup present (stable 10 cycles), Making rises at edge k -> Grinder high cycles k..k+7; Pump high k+8..k+27; Done single pulse at k+28; MilkValve never high.
- Latte, same setup -> MilkValve high k+28..k+39; Done at k+40. Then Coffee=1 with CupSensor low for 4+2 cycles -> single TakeOut pulse; ServedCnt 0->1; state IDLE.
- No cup, Making=1 -> CupAlarm=1, no actuators. Cup inserted -> Grinder rises DEB_CYC+2 cycles after the sensor rises. A 3-cycle sensor glitch produces no change.
- Cup removed after 5 BREW cycles -> Pump off, CupAlarm=1. Cup restored -> Pump resumes for exactly 15 more cycles, then Done. Total Pump-on count is 20.
- Kind=00 with Making=1 -> KindErr pulse, Done pulse, no actuator activity. Making dropped mid-GRIND -> Grinder off next cycle, no Done, IDLE.
- Async RST asserted mid-BREW between clock edges -> Pump=0 immediately, ServedCnt=0. Also: ServedCnt preset path via 65535 TakeOuts (or forced) stays at FFFF on a further TakeOut.
